// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine.
//   GCD_W / GCD_KW : operand width and width of the power-of-two counter k
//   gcd_state_e    : engine state encoding (READY=0, RUN=1)
//   gcd_max_cycles : worst-case RUN cycles for one request (2*GCD_W+1)
package gcd_pkg;

  localparam int GCD_W  = 18;
  localparam int GCD_KW = 5;

  typedef enum logic {
    ST_GCD_READY = 1'b0,
    ST_GCD_RUN   = 1'b1
  } gcd_state_e;

  // Every non-terminal step strips at least one bit from x or y, so the
  // total is 2*W non-terminal steps plus the terminal one.
  function automatic int gcd_max_cycles();
    return 2 * GCD_W + 1;
  endfunction

endpackage

// File: rtl/binary_gcd_step.sv
// One step of Stein's binary GCD, purely combinational.
// Ports:
//   x_i, y_i   current operands
//   k_i        count of common factors of two removed so far
//   x_o, y_o   next operands
//   k_o        next common-power counter
//   done_o     one operand is zero; gcd_o is valid
//   gcd_o      the nonzero operand shifted back up by k
module binary_gcd_step
  import gcd_pkg::*;
#(
  parameter int W  = GCD_W,
  parameter int KW = GCD_KW
) (
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  input  logic [KW-1:0] k_i,
  output logic [W-1:0]  x_o,
  output logic [W-1:0]  y_o,
  output logic [KW-1:0] k_o,
  output logic          done_o,
  output logic [W-1:0]  gcd_o
);

  logic [W-1:0] diff_xy, diff_yx;

  // Only the non-negative one is ever used.
  assign diff_xy = x_i - y_i;
  assign diff_yx = y_i - x_i;

  always_comb begin
    x_o    = x_i;
    y_o    = y_i;
    k_o    = k_i;
    done_o = 1'b0;
    gcd_o  = '0;
    if (x_i == '0) begin
      done_o = 1'b1;
      gcd_o  = y_i << k_i;
    end else if (y_i == '0) begin
      done_o = 1'b1;
      gcd_o  = x_i << k_i;
    end else if (!x_i[0] && !y_i[0]) begin
      x_o = x_i >> 1;
      y_o = y_i >> 1;
      k_o = k_i + KW'(1);
    end else if (!x_i[0]) begin
      x_o = x_i >> 1;
    end else if (!y_i[0]) begin
      y_o = y_i >> 1;
    end else if (x_i >= y_i) begin
      // odd - odd is even, so the halving loses nothing
      x_o = diff_xy >> 1;
    end else begin
      y_o = diff_yx >> 1;
    end
  end

endmodule

// File: rtl/binary_gcd_18_18_18.sv
// Iterative binary (Stein) GCD engine, one step per clock.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   start         one-cycle request, samples a and b; restarts a running job
//   a, b          18-bit unsigned operands
//   result        gcd of the last completed request (held until next completion)
//   result_ready  high when idle and start is low
// Optional: BINARY_GCD_UNIT_SHORTCUT_EN - an operand of 1 completes at the
// start edge with result 1, never entering RUN.
module binary_gcd_18_18_18
  import gcd_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int KW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_ready
);

  if (WIDTH != GCD_W) begin : g_bad_width
    $error("binary_gcd_18_18_18: only WIDTH=18 is supported");
  end

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;

  logic [WIDTH-1:0] step_x, step_y, step_gcd;
  logic [KW-1:0]    step_k;
  logic             step_done;

  binary_gcd_step #(.W(WIDTH), .KW(KW)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .k_i    (k_q),
    .x_o    (step_x),
    .y_o    (step_y),
    .k_o    (step_k),
    .done_o (step_done),
    .gcd_o  (step_gcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_GCD_READY;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result_q;
    if (start) begin
`ifdef BINARY_GCD_UNIT_SHORTCUT_EN
      if (a == WIDTH'(1) || b == WIDTH'(1)) begin
        result_d = WIDTH'(1);
        state_d  = ST_GCD_READY;
      end else begin
        x_d     = a;
        y_d     = b;
        k_d     = '0;
        state_d = ST_GCD_RUN;
      end
`else
      x_d     = a;
      y_d     = b;
      k_d     = '0;
      state_d = ST_GCD_RUN;
`endif
    end else if (state_q == ST_GCD_RUN) begin
      if (step_done) begin
        result_d = step_gcd;
        state_d  = ST_GCD_READY;
      end else begin
        x_d = step_x;
        y_d = step_y;
        k_d = step_k;
      end
    end
  end

  // Combinational on purpose: the consumer relies on ready falling in the
  // same cycle start is raised.
  assign result_ready = (state_q == ST_GCD_READY) && !start;
  assign result       = result_q;

endmodule

// File: tb/tb_binary_gcd_18_18_18.sv
module tb_binary_gcd_18_18_18;
  import gcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] a = '0, b = '0;
  logic [17:0] result;
  logic        result_ready;

  int nvec = 0;
  int nerr = 0;

  binary_gcd_18_18_18 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .result       (result),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  // Euclid's algorithm: independent of the shift/subtract method under test.
  function automatic logic [17:0] ref_gcd(input logic [17:0] av, input logic [17:0] bv);
    logic [17:0] p, q, t;
    p = av; q = bv;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // Issue one request and wait for completion; cyc = RUN cycles after the start edge.
  task automatic run_gcd(input logic [17:0] av, input logic [17:0] bv,
                         output logic [17:0] res, output int cyc);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    #1;
    nvec++;
    if (result_ready !== 1'b0) begin
      nerr++;
      $display("FAIL ready_drop a=%0d b=%0d got %b want 0", av, bv, result_ready);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (result_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    res = result;
    nvec++;
    if (cyc > gcd_max_cycles()) begin
      nerr++;
      $display("FAIL latency_bound a=%0d b=%0d got %0d cycles want <= %0d", av, bv, cyc, gcd_max_cycles());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (result !== 18'd0) begin nerr++; $display("FAIL reset_result got %0d want 0", result); end
    nvec++;
    if (result_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", result_ready); end
  endtask

  task automatic test_basic();
    logic [17:0] res; int cyc;
    run_gcd(18'd12, 18'd18, res, cyc);
    nvec++;
    if (res !== 18'd6) begin nerr++; $display("FAIL basic_12_18 got %0d want 6", res); end
    // (12,18)->(6,9,k1)->(3,9)->(3,3)->(0,3)->done: 5 RUN cycles
    nvec++;
    if (cyc != 5) begin nerr++; $display("FAIL basic_12_18_latency got %0d want 5", cyc); end
  endtask

  task automatic test_zero();
    logic [17:0] av[3], bv[3], ex[3], res; int cyc;
    av = '{18'd0, 18'd0, 18'd262143};
    bv = '{18'd0, 18'd131071, 18'd0};
    ex = '{18'd0, 18'd131071, 18'd262143};
    for (int i = 0; i < 3; i++) begin
      run_gcd(av[i], bv[i], res, cyc);
      nvec++;
      if (res !== ex[i]) begin nerr++; $display("FAIL zero_val a=%0d b=%0d got %0d want %0d", av[i], bv[i], res, ex[i]); end
      nvec++;
      if (cyc != 1) begin nerr++; $display("FAIL zero_latency a=%0d b=%0d got %0d want 1", av[i], bv[i], cyc); end
    end
  endtask

  task automatic test_restart();
    logic [17:0] prev; int cyc;
    prev = result;
    @(negedge clk);
    a = 18'd262142; b = 18'd131071; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin a = 18'd36; b = 18'd48; start = 1'b1; #1; end
      nvec++;
      if (result_ready !== 1'b0) begin nerr++; $display("FAIL restart_ready step=%0d got %b want 0", i, result_ready); end
      nvec++;
      if (result !== prev) begin nerr++; $display("FAIL restart_hold step=%0d got %0d want %0d", i, result, prev); end
      if (i < 2) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (result_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    nvec++;
    if (result !== 18'd12) begin nerr++; $display("FAIL restart_result got %0d want 12", result); end
    nvec++;
    if (cyc > gcd_max_cycles()) begin nerr++; $display("FAIL restart_latency got %0d want <= %0d", cyc, gcd_max_cycles()); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a = 18'd262143; b = 18'd131070; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (result !== 18'd0) begin nerr++; $display("FAIL midrun_reset_result got %0d want 0", result); end
    nvec++;
    if (result_ready !== 1'b1) begin nerr++; $display("FAIL midrun_reset_ready got %b want 1", result_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unit();
    logic [17:0] res; int cyc;
    run_gcd(18'd1, 18'd99991, res, cyc);
    nvec++;
    if (res !== 18'd1) begin nerr++; $display("FAIL unit_val got %0d want 1", res); end
    run_gcd(18'd1, 18'd1, res, cyc);
    nvec++;
    if (res !== 18'd1) begin nerr++; $display("FAIL unit11_val got %0d want 1", res); end
`ifdef BINARY_GCD_UNIT_SHORTCUT_EN
    nvec++;
    if (cyc != 0) begin nerr++; $display("FAIL unit11_latency got %0d want 0", cyc); end
`else
    nvec++;
    if (cyc != 2) begin nerr++; $display("FAIL unit11_latency got %0d want 2", cyc); end
`endif
  endtask

  task automatic test_random();
    logic [17:0] av, bv, res, ex; int cyc;
    for (int i = 0; i < 1200; i++) begin
      av = 18'($urandom);
      bv = 18'($urandom);
      if (i % 8 == 1) bv = av * 18'($urandom_range(1, 3));
      if (i % 8 == 2) av = av & 18'h3ff00;
      run_gcd(av, bv, res, cyc);
      ex = ref_gcd(av, bv);
      nvec++;
      if (res !== ex) begin nerr++; $display("FAIL random a=%0d b=%0d got %0d want %0d", av, bv, res, ex); end
    end
  endtask

  task automatic test_totient();
    logic [17:0] res; int cyc, cnt;
    cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      run_gcd(18'(i), 18'd36, res, cyc);
      nvec++;
      if (res !== ref_gcd(18'(i), 18'd36)) begin nerr++; $display("FAIL totient_gcd i=%0d got %0d want %0d", i, res, ref_gcd(18'(i), 18'd36)); end
      if (res == 18'd1) cnt++;
    end
    nvec++;
    if (cnt != 12) begin nerr++; $display("FAIL totient_36 got %0d want 12", cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_restart();
    test_reset_midrun();
    test_unit();
    test_random();
    test_totient();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
